// File: rtl/fetch_aligner.sv
// fetch_aligner: RV32EC instruction fetch front end.
// Issues word-aligned reads to instruction memory, buffers up to three
// returned halfwords and hands one aligned 16- or 32-bit instruction per
// handshake to the decoder. A redirect flushes the buffer and restarts fetch.
module fetch_aligner #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        MemReqValid,
   output logic [31:0] MemReqAddr,
   input  logic        MemReqReady,
   input  logic        MemRspValid,
   input  logic [31:0] MemRspData,
   input  logic        Redirect,
   input  logic [31:0] RedirectAddr,
   output logic        InstValid,
   input  logic        InstReady,
   output logic [31:0] InstData,
   output logic [31:0] InstAddr,
   output logic        InstCompressed
);

   localparam logic [1:0] ST_REQ  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_KILL = 2'd3;

   logic [1:0]  r_state;
   logic [15:0] r_hw [0:2];
   logic [1:0]  r_count;
   logic [31:0] r_instAddr;
   logic [31:0] r_fetchAddr;
   logic        r_skipLow;

   logic        w_isC;
   logic        w_instValid;
   logic        w_consume;
   logic        w_take;
   logic        w_reqFire;
   logic [1:0]  w_used;
   logic [1:0]  w_base;
   logic [1:0]  w_nextCount;
   logic [15:0] w_next [0:2];
   logic [31:0] w_redirPc;
   logic [31:0] w_redirFetch;

   // The oldest halfword decides the instruction length; a 32-bit one
   // needs its upper half present before it can be presented.
   assign w_isC        = r_hw[0][1:0] != 2'b11;
   assign w_instValid  = (r_count != 2'd0) && (w_isC || (r_count >= 2'd2));
   assign w_consume    = w_instValid && InstReady && !Redirect;
   assign w_used       = !w_consume ? 2'd0 : (w_isC ? 2'd1 : 2'd2);
   assign w_take       = MemRspValid && (r_state == ST_WAIT) && !Redirect;
   assign w_reqFire    = (r_state == ST_REQ) && MemReqReady;
   assign w_base       = r_count - w_used;
   assign w_redirPc    = RedirectAddr & 32'hFFFF_FFFE;
   assign w_redirFetch = RedirectAddr & 32'hFFFF_FFFC;

   assign MemReqValid    = (r_state == ST_REQ) && !rst;
   assign MemReqAddr     = r_fetchAddr;
   assign InstValid      = w_instValid;
   assign InstData       = !w_instValid ? 32'h0 :
                           (w_isC ? {16'h0, r_hw[0]} : {r_hw[1], r_hw[0]});
   assign InstAddr       = r_instAddr;
   assign InstCompressed = w_instValid && w_isC;

   // Next buffer contents: shift out consumed halfwords, then append the
   // response halves behind whatever remains (only the upper half when the
   // fetch started mid-word).
   always_comb begin
      w_nextCount = w_base;
      w_next[0]   = 16'h0;
      w_next[1]   = 16'h0;
      w_next[2]   = 16'h0;
      case (w_used)
         2'd0: begin
            w_next[0] = r_hw[0];
            w_next[1] = r_hw[1];
            w_next[2] = r_hw[2];
         end
         2'd1: begin
            w_next[0] = r_hw[1];
            w_next[1] = r_hw[2];
         end
         default: begin
            w_next[0] = r_hw[2];
         end
      endcase
      if (w_take) begin
         if (r_skipLow) begin
            w_nextCount = w_base + 2'd1;
         end else begin
            w_nextCount = w_base + 2'd2;
         end
         for (int i = 0; i < 3; i++) begin
            if (r_skipLow) begin
               if (w_base == 2'(i)) w_next[i] = MemRspData[31:16];
            end else begin
               if (w_base == 2'(i)) w_next[i] = MemRspData[15:0];
               else if ((w_base + 2'd1) == 2'(i)) w_next[i] = MemRspData[31:16];
            end
         end
      end
   end

   // Halfword buffer and fill level; a redirect empties it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) r_hw[i] <= 16'h0;
         r_count <= 2'd0;
      end else begin
         for (int i = 0; i < 3; i++) r_hw[i] <= w_next[i];
         r_count <= Redirect ? 2'd0 : w_nextCount;
      end
   end

   // Instruction address, fetch address and the mid-word start flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instAddr  <= RESET_PC;
         r_fetchAddr <= RESET_PC & 32'hFFFF_FFFC;
         r_skipLow   <= RESET_PC[1];
      end else if (Redirect) begin
         r_instAddr  <= w_redirPc;
         r_fetchAddr <= w_redirFetch;
         r_skipLow   <= w_redirPc[1];
      end else begin
         if (w_consume) r_instAddr <= r_instAddr + (w_isC ? 32'd2 : 32'd4);
         if (w_reqFire) r_fetchAddr <= r_fetchAddr + 32'd4;
         if (w_take) r_skipLow <= 1'b0;
      end
   end

   // Request sequencing with a single outstanding read; KILL swallows the
   // response of a read that was in flight when a redirect hit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_REQ;
      end else if (Redirect) begin
         case (r_state)
            ST_WAIT, ST_KILL: r_state <= MemRspValid ? ST_REQ : ST_KILL;
            ST_REQ:           r_state <= MemReqReady ? ST_KILL : ST_REQ;
            default:          r_state <= ST_REQ;
         endcase
      end else begin
         case (r_state)
            ST_REQ: begin
               if (MemReqReady) r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (MemRspValid) r_state <= (w_nextCount <= 2'd1) ? ST_REQ : ST_HOLD;
            end
            ST_HOLD: begin
               if (w_nextCount <= 2'd1) r_state <= ST_REQ;
            end
            default: begin
               if (MemRspValid) r_state <= ST_REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: randomized bench for fetch_aligner with a memory
// responder, an instruction-stream reference model and a scoreboard.
module tb_fetch_aligner;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemReqValid;
   logic [31:0] MemReqAddr;
   logic        MemReqReady;
   logic        MemRspValid;
   logic [31:0] MemRspData;
   logic        Redirect;
   logic [31:0] RedirectAddr;
   logic        InstValid;
   logic        InstReady;
   logic [31:0] InstData;
   logic [31:0] InstAddr;
   logic        InstCompressed;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        comp;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] mem [0:127];
   int          nCompared = 0;
   int          nMismatched = 0;
   int          nPopped = 0;
   bit          fastMem = 1'b1;
   bit          memStall = 1'b0;
   int          memReadyPct = 75;
   int          maxLat = 4;
   bit          pending = 1'b0;
   bit          acceptSeen = 1'b0;
   int          sinceRedir = 0;

   fetch_aligner #(.RESET_PC(TB_RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .MemReqValid(MemReqValid), .MemReqAddr(MemReqAddr), .MemReqReady(MemReqReady),
      .MemRspValid(MemRspValid), .MemRspData(MemRspData),
      .Redirect(Redirect), .RedirectAddr(RedirectAddr),
      .InstValid(InstValid), .InstReady(InstReady), .InstData(InstData),
      .InstAddr(InstAddr), .InstCompressed(InstCompressed)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] halfAt(input logic [31:0] a);
      return a[1] ? mem[a[8:2]][31:16] : mem[a[8:2]][15:0];
   endfunction

   // Reference model: decode the program stream starting at a halfword address.
   function automatic void refill(input logic [31:0] start);
      logic [31:0] pc;
      logic [15:0] lo;
      exp_t        e;
      expQ.delete();
      pc = start & 32'hFFFF_FFFE;
      for (int n = 0; n < 400; n++) begin
         lo = halfAt(pc);
         e.addr = pc;
         if (lo[1:0] != 2'b11) begin
            e.data = {16'h0, lo};
            e.comp = 1'b1;
            pc = pc + 32'd2;
         end else begin
            e.data = {halfAt(pc + 32'd2), lo};
            e.comp = 1'b0;
            pc = pc + 32'd4;
         end
         expQ.push_back(e);
      end
   endfunction

   // Memory responder: one read in flight, checks request ordering and stability.
   logic [31:0] expFetch;
   logic [31:0] pAddr;
   logic [31:0] prevAddr;
   bit          prevReqWait = 1'b0;
   int          lat = 0;
   always @(negedge clk) begin
      if (rst) begin
         MemRspValid = 1'b0;
         MemReqReady = 1'b0;
         pending     = 1'b0;
         prevReqWait = 1'b0;
         expFetch    = TB_RESET_PC & 32'hFFFF_FFFC;
      end else begin
         MemRspValid = 1'b0;
         if (pending) begin
            lat = lat - 1;
            if (lat == 0) begin
               MemRspValid = 1'b1;
               MemRspData  = mem[pAddr[8:2]];
               pending     = 1'b0;
            end
         end
         if (prevReqWait) begin
            checkOutput("reqValidHold", 32'(MemReqValid), 32'd1);
            checkOutput("reqAddrHold", MemReqAddr, prevAddr);
         end
         MemReqReady = memStall ? 1'b0 : (fastMem ? 1'b1 : ($urandom_range(99) < memReadyPct));
         if (MemReqValid && MemReqReady) begin
            checkOutput("oneOutstanding", 32'(pending), 32'd0);
            if (!Redirect) begin
               checkOutput("reqAddr", MemReqAddr, expFetch);
               expFetch = expFetch + 32'd4;
            end
            pending    = 1'b1;
            pAddr      = MemReqAddr;
            lat        = fastMem ? 1 : int'($urandom_range(maxLat, 1));
            acceptSeen = 1'b1;
         end
         if (Redirect) expFetch = RedirectAddr & 32'hFFFF_FFFC;
         prevReqWait = MemReqValid && !MemReqReady && !Redirect;
         prevAddr    = MemReqAddr;
      end
   end

   // Monitor: compare every presented instruction against the scoreboard head.
   int   idle = 0;
   exp_t head;
   always @(negedge clk) begin
      if (rst) begin
         idle = 0;
      end else begin
         if (InstValid && !Redirect) begin
            if (expQ.size() == 0) begin
               nCompared++;
               nMismatched++;
               $display("[TB] FAIL scoreboardEmpty: got instruction at %h, required none", InstAddr);
            end else begin
               head = expQ[0];
               checkOutput("instAddr", InstAddr, head.addr);
               checkOutput("instData", InstData, head.data);
               checkOutput("instComp", 32'(InstCompressed), 32'(head.comp));
               if (InstReady) begin
                  void'(expQ.pop_front());
                  nPopped++;
               end
            end
         end
         if (InstValid && InstReady && !Redirect) begin
            idle = 0;
         end else if (InstReady && !memStall) begin
            idle++;
            if (idle > 100) begin
               nCompared++;
               nMismatched++;
               $display("[TB] FAIL progress: got no instruction for %0d cycles, required fewer than 100", idle);
               idle = 0;
            end
         end
      end
   end

   // Drive decoder readiness and occasional redirects for a number of cycles.
   task automatic applyStimulus(input int cycles, input int rdyPct, input int redirPct);
      logic [31:0] target;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         Redirect = 1'b0;
         sinceRedir++;
         if (redirPct > 0 && (($urandom_range(99) < redirPct) || sinceRedir > 200)) begin
            target       = $urandom_range(32'h1FF);
            RedirectAddr = target;
            Redirect     = 1'b1;
            refill(target);
            sinceRedir   = 0;
         end
         InstReady = ($urandom_range(99) < rdyPct);
      end
   endtask

   task automatic checkResetOutputs();
      checkOutput("rstReqValid", 32'(MemReqValid), 32'd0);
      checkOutput("rstReqAddr", MemReqAddr, TB_RESET_PC & 32'hFFFF_FFFC);
      checkOutput("rstInstValid", 32'(InstValid), 32'd0);
      checkOutput("rstInstData", InstData, 32'd0);
      checkOutput("rstInstAddr", InstAddr, TB_RESET_PC);
      checkOutput("rstInstComp", 32'(InstCompressed), 32'd0);
   endtask

   // Absolute time limit so the run always ends.
   initial begin
      #400000;
      $display("[TB] FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "[TB] time limit");
   end

   // Main sequence.
   initial begin
      logic [15:0] hw;
      logic [31:0] w;
      rst          = 1'b1;
      Redirect     = 1'b0;
      RedirectAddr = 32'h0;
      InstReady    = 1'b0;
      for (int i = 0; i < 128; i++) begin
         for (int h = 0; h < 2; h++) begin
            hw = 16'($urandom);
            if ($urandom_range(2) == 0) hw[1:0] = 2'b11;
            else if (hw[1:0] == 2'b11) hw[1:0] = 2'b01;
            if (h == 0) w[15:0] = hw;
            else w[31:16] = hw;
         end
         mem[i] = w;
      end
      mem[0] = 32'h0000_0513;
      mem[1] = 32'h4505_4501;
      mem[2] = 32'h0513_4501;

      repeat (2) @(posedge clk);
      #1;
      checkResetOutputs();
      refill(TB_RESET_PC);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      InstReady = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (k == 0) checkOutput("reqValidAfterReset", 32'(MemReqValid), 32'd1);
         checkOutput("firstValidTiming", 32'(InstValid), (k == 2) ? 32'd1 : 32'd0);
      end
      applyStimulus(30, 100, 0);

      // Decoder stall: outputs hold, fetch stops once the buffer is full.
      applyStimulus(10, 0, 0);
      @(negedge clk);
      checkOutput("stallReqValid", 32'(MemReqValid), 32'd0);
      applyStimulus(20, 100, 0);

      // Memory stall: request held with a constant address.
      memStall = 1'b1;
      applyStimulus(5, 100, 0);
      @(negedge clk);
      checkOutput("memStallReqValid", 32'(MemReqValid), 32'd1);
      memStall = 1'b0;
      applyStimulus(10, 100, 0);

      // Redirect to 0x102 in the cycle after a request is accepted.
      Redirect   = 1'b0;
      acceptSeen = 1'b0;
      for (int i = 0; i < 50 && !acceptSeen; i++) @(posedge clk);
      if (!acceptSeen) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL acceptWait: got no accepted request in 50 cycles, required one");
      end
      #1;
      RedirectAddr = 32'h0000_0102;
      Redirect     = 1'b1;
      refill(32'h0000_0102);
      sinceRedir   = 0;
      applyStimulus(40, 100, 0);

      // Random traffic with variable memory latency and redirects.
      fastMem = 1'b0;
      applyStimulus(1500, 75, 3);

      // Reset while a read is outstanding.
      Redirect = 1'b0;
      for (int i = 0; i < 100 && !pending; i++) begin
         @(posedge clk);
         #1;
      end
      if (!pending) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL waitOutstanding: got no read in flight, required one");
      end
      rst = 1'b1;
      #1;
      checkResetOutputs();
      refill(TB_RESET_PC);
      sinceRedir = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(300, 75, 3);
      Redirect  = 1'b0;
      InstReady = 1'b0;
      repeat (2) @(posedge clk);

      checkOutput("streamProgress", 32'(nPopped > 200), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
